exp_series_gen: RTL
===================

// Module: exp_series_gen
// PURPOSE
//  Parametrised successor to the fixed 18-bit/512-entry exp(mu) table builder.
//  - Fills a table RAM with E[k] = A*R^k (geometric mode) or E[k] = A + k*R (linear mode).
//  - Geometric mode gives exp(mu + k*s) when A = exp(mu) and R = exp(s).
//  - Drives one table write (address/data/strobe) per clock. Table length is programmable.
//  - Adds saturation flagging and abort support.
// PARAMETERS
//  DW    18  data width; unsigned fixed point, FRAC fractional bits
//  FRAC  12  fractional bits of A, R and E (4096 = 1.0 at defaults)
//  AW    9   address width; max table depth 2**AW
// PORTS
//  CLK     in   1      clock; all logic on rising edge
//  RST     in   1      synchronous active-high reset
//  iA      in   DW     initial term E[0]
//  iR      in   DW     ratio (geometric) or increment (linear)
//  iMode   in   1      0 = geometric, 1 = linear
//  iLen    in   AW     number of terms; 0 means 2**AW
//  iStart  in   1      start pulse; sampled only in IDLE
//  iAbort  in   1      cancel the current run
//  oData   out  DW     table write data
//  oAddr   out  AW     table write address
//  oWe     out  1      write strobe; oData/oAddr are valid when high
//  oBusy   out  1      high while in RUN
//  oDone   out  1      single-cycle pulse when a run completes
//  oSat    out  1      sticky: a saturation occurred in the current/last run
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; internal registers cleared. Applies mid-run too:
//    oWe and oBusy drop in the cycle after RST is sampled, and there is no oDone.
//  - States: IDLE -> RUN on iStart. RUN -> DONE after the last write. RUN -> IDLE on iAbort.
//    DONE -> IDLE unconditionally after one cycle.
//  - Start: iStart sampled high in IDLE at edge N
//    - latches iA, iR, iMode, iLen
//    - clears oSat
//    - first write at edge N+1: oAddr=0, oData=iA, oWe=1, oBusy=1.
//  - RUN: one term per cycle, no bubbles.
//    - oAddr increments by 1 each write.
//    - Last write has oAddr = Len-1 (2**AW-1 when iLen = 0).
//  - DONE (cycle after last write): oWe=0, oBusy=0, oDone=1 for exactly one cycle.
//  - Geometric step: P = E*R, full 2*DW-bit product.
//    - E' = P >> FRAC (truncate toward zero).
//    - If P >> FRAC > 2**DW-1, then E' = 2**DW-1 and oSat <= 1.
//  - Linear step: S = E + R, DW+1 bits.
//    - If S > 2**DW-1, then E' = 2**DW-1 and oSat <= 1.
//  - Once E is saturated it stays saturated for the remaining terms, except in geometric mode
//    with R < 1.0, where the normal truncating step applies.
//  - iStart in RUN or DONE is ignored; latched operands are unaffected.
//  - iAbort sampled in RUN: next cycle oWe=0, oBusy=0, state IDLE, no oDone.
//    - Writes already issued stand. oSat keeps its value.
//    - iAbort in IDLE or DONE has no effect.
//  - iStart and iAbort high together in IDLE: start wins. iAbort is evaluated from RUN on.
//  - iA = 0 is legal: all terms are 0 in geometric mode.
//  - oData/oAddr hold their last values when oWe=0; consumers must qualify them with oWe.
//  - Multiply maps to a DSP block; the E update is registered with no extra pipeline, so the
//    step is combinational-to-register in one cycle.
// TESTING (defaults DW=18, FRAC=12, AW=9)
//  1. Geometric, iA=4096, iR=8192, iLen=4, pulse iStart
//     -> writes (0,4096) (1,8192) (2,16384) (3,32768) on consecutive cycles;
//        oDone one cycle after addr 3; oSat=0.
//  2. Saturation, iA=131072, iR=8192, iLen=3
//     -> data 131072, 262143, 262143; oSat=1 from the second write on; oDone pulses.
//  3. Linear, iMode=1, iA=184, iR=24576, iLen=3
//     -> data 184, 24760, 49336 at addr 0..2.
//  4. iLen=0, iR=4096 -> exactly 512 writes, addr 0..511, all data = iA, then oDone.
//  5. Abort at the third write of iLen=10 -> oWe low next cycle, oBusy=0, no oDone;
//     a new iStart then restarts from addr 0.
//  6. iStart during RUN ignored (run length/data unchanged); RST at addr 5
//     -> all outputs 0 next cycle, no oDone.

Source files
------------

// File: rtl/exp_series_gen.sv
// Table builder: streams E[k] = A*R^k (geometric) or E[k] = A + k*R (linear)
// as one address/data write per clock, with saturation flagging and abort.
module exp_series_gen #(
    parameter int DW   = 18,
    parameter int FRAC = 12,
    parameter int AW   = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] iA,
    input  logic [DW-1:0] iR,
    input  logic          iMode,
    input  logic [AW-1:0] iLen,
    input  logic          iStart,
    input  logic          iAbort,
    output logic [DW-1:0] oData,
    output logic [AW-1:0] oAddr,
    output logic          oWe,
    output logic          oBusy,
    output logic          oDone,
    output logic          oSat,
    output logic [1:0]    oState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] MAX_VAL = '1;

    state_t        state;
    state_t        stateNext;

    logic [DW-1:0] rReg;
    logic          modeReg;
    logic [AW-1:0] lastAddr;

    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] prodShift;
    logic [DW:0]     sum;
    logic [DW-1:0]   stepData;
    logic            stepSat;

    logic [DW-1:0] dataNext;
    logic [AW-1:0] addrNext;
    logic          weNext;
    logic          busyNext;
    logic          doneNext;
    logic          satNext;
    logic          loadOps;

    assign oState = state;

    // One term per clock: the step is a single combinational multiply/add
    // feeding the oData register, which doubles as the running term E.
    always_comb begin
        prod      = {{DW{1'b0}}, oData} * {{DW{1'b0}}, rReg};
        prodShift = prod >> FRAC;
        sum       = {1'b0, oData} + {1'b0, rReg};
        stepData  = '0;
        stepSat   = 1'b0;
        if (modeReg) begin
            if (sum[DW]) begin
                stepData = MAX_VAL;
                stepSat  = 1'b1;
            end else begin
                stepData = sum[DW-1:0];
            end
        end else begin
            if (|prodShift[2*DW-1:DW]) begin
                stepData = MAX_VAL;
                stepSat  = 1'b1;
            end else begin
                stepData = prodShift[DW-1:0];
            end
        end
    end

    // Write handshake: a consumer takes (oAddr, oData) on every rising edge
    // where oWe is high; there is no back-pressure, and oAddr/oData simply
    // hold their last values while oWe is low.
    always_comb begin
        stateNext = state;
        dataNext  = oData;
        addrNext  = oAddr;
        weNext    = 1'b0;
        busyNext  = 1'b0;
        doneNext  = 1'b0;
        satNext   = oSat;
        loadOps   = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = RUN;
                    loadOps   = 1'b1;
                    dataNext  = iA;
                    addrNext  = '0;
                    weNext    = 1'b1;
                    busyNext  = 1'b1;
                    satNext   = 1'b0;
                end
            end
            RUN: begin
                if (iAbort) begin
                    stateNext = IDLE;
                end else if (oAddr == lastAddr) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    dataNext = stepData;
                    addrNext = oAddr + 1'b1;
                    weNext   = 1'b1;
                    busyNext = 1'b1;
                    satNext  = oSat | stepSat;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            rReg     <= '0;
            modeReg  <= 1'b0;
            lastAddr <= '0;
            oData    <= '0;
            oAddr    <= '0;
            oWe      <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oSat     <= 1'b0;
        end else begin
            state <= stateNext;
            oData <= dataNext;
            oAddr <= addrNext;
            oWe   <= weNext;
            oBusy <= busyNext;
            oDone <= doneNext;
            oSat  <= satNext;
            if (loadOps) begin
                rReg    <= iR;
                modeReg <= iMode;
                // Length 0 wraps to all-ones, i.e. a full 2**AW-entry table.
                lastAddr <= iLen - 1'b1;
            end
        end
    end

endmodule
